// File: rtl/tm_fsm_core_pkg.sv
// Shared encodings for the Turing-machine control core: control FSM states,
// reserved machine-state values and table-entry field positions.
package tm_fsm_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_FETCH, ST_IOWAIT, ST_MOVE, ST_HALT
  } fsm_e;

  // Reserved machine states live at the top of the state space.
  function automatic int unsigned tm_init(int unsigned state_w);
    return 0;
  endfunction

  function automatic int unsigned tm_halt_st(int unsigned state_w);
    return (32'd1 << state_w) - 32'd1;
  endfunction

  function automatic int unsigned tm_io_wr(int unsigned state_w);
    return tm_halt_st(state_w) - 32'd1;
  endfunction

  function automatic int unsigned tm_io_rd(int unsigned state_w);
    return tm_halt_st(state_w) - 32'd2;
  endfunction

  // Entry layout: {new symbol, dir, next state}
  function automatic int unsigned ent_dir_pos(int unsigned state_w);
    return state_w;
  endfunction

  function automatic int unsigned ent_sym_lsb(int unsigned state_w);
    return state_w + 32'd1;
  endfunction

endpackage

// File: rtl/tm_fsm_core_step_counter.sv
// Saturating completed-step counter with synchronous clear.
module tm_step_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/tm_fsm_core.sv
// Turing-machine control core: sequences tape read, table fetch, optional
// GPIO exchange and tape write/move for each machine step.
module tm_fsm_core
  import tm_fsm_core_pkg::*;
#(
  parameter  int STATE_W = 7,
  parameter  int SYM_W   = 8,
  parameter  int STEP_W  = 16,
  localparam int ADDR_W  = STATE_W + SYM_W + 1,
  localparam int ENTRY_W = SYM_W + 1 + STATE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               step_i,
  input  logic               clear_i,
  input  logic               bp_en_i,
  input  logic [STATE_W-1:0] bp_state_i,
  output logic               tbl_valid_o,
  output logic [ADDR_W-1:0]  tbl_addr_o,
  input  logic               tbl_done_i,
  input  logic [ENTRY_W-1:0] tbl_data_i,
  input  logic               tape_valid_i,
  input  logic [SYM_W-1:0]   tape_sym_i,
  output logic               tape_move_o,
  output logic               tape_dir_o,
  output logic [SYM_W-1:0]   tape_data_o,
  input  logic               tape_done_i,
  input  logic [SYM_W-1:0]   gpio_i,
  input  logic               gpio_valid_i,
  output logic [SYM_W-1:0]   gpio_o,
  output logic               gpio_stb_o,
  output logic [STATE_W-1:0] tm_state_o,
  output logic [STEP_W-1:0]  step_cnt_o,
  output logic               halted_o,
  output logic               busy_o
);

  localparam logic [STATE_W-1:0] INIT    = STATE_W'(tm_init(STATE_W));
  localparam logic [STATE_W-1:0] HALT_ST = STATE_W'(tm_halt_st(STATE_W));
  localparam logic [STATE_W-1:0] IO_WR   = STATE_W'(tm_io_wr(STATE_W));
  localparam logic [STATE_W-1:0] IO_RD   = STATE_W'(tm_io_rd(STATE_W));
  localparam int DIR_POS = ent_dir_pos(STATE_W);
  localparam int SYM_LSB = ent_sym_lsb(STATE_W);

  fsm_e               fsm, fsm_nxt;
  logic [STATE_W-1:0] tm_state, nst_q;
  logic [SYM_W-1:0]   sym_q;
  logic               ss_q;

  wire [STATE_W-1:0] ent_nst = tbl_data_i[STATE_W-1:0];
  wire               ent_dir = tbl_data_i[DIR_POS];
  wire [SYM_W-1:0]   ent_sym = tbl_data_i[ENTRY_W-1:SYM_LSB];

  wire stop_after = (bp_en_i && nst_q == bp_state_i) || ss_q || !run_i;
  wire cnt_inc    = (fsm == ST_MOVE) && tape_done_i;
  wire cnt_clr    = (fsm == ST_HALT) && clear_i;

  assign tbl_addr_o = {tm_state, sym_q, 1'b0};
  assign tm_state_o = tm_state;

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      ST_IDLE:   if (run_i || step_i) fsm_nxt = ST_READ;
      ST_READ:   if (tape_valid_i)    fsm_nxt = ST_FETCH;
      ST_FETCH:  if (tbl_done_i)
                   fsm_nxt = (tm_state == IO_RD && !gpio_valid_i) ? ST_IOWAIT : ST_MOVE;
      ST_IOWAIT: if (gpio_valid_i)    fsm_nxt = ST_MOVE;
      ST_MOVE:   if (tape_done_i) begin
                   if (nst_q == HALT_ST) fsm_nxt = ST_HALT;
                   else if (stop_after)  fsm_nxt = ST_IDLE;
                   else                  fsm_nxt = ST_READ;
                 end
      ST_HALT:   if (clear_i)         fsm_nxt = ST_IDLE;
      default:                        fsm_nxt = ST_IDLE;
    endcase
  end

  // Status/request outputs are registered from the next state so they
  // change on the same edge as the FSM and drop straight to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= ST_IDLE;
      tm_state    <= INIT;
      nst_q       <= '0;
      sym_q       <= '0;
      ss_q        <= 1'b0;
      tape_dir_o  <= 1'b0;
      tape_data_o <= '0;
      gpio_o      <= '0;
      gpio_stb_o  <= 1'b0;
      tbl_valid_o <= 1'b0;
      tape_move_o <= 1'b0;
      halted_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      fsm         <= fsm_nxt;
      tbl_valid_o <= (fsm_nxt == ST_FETCH);
      tape_move_o <= (fsm_nxt == ST_MOVE);
      halted_o    <= (fsm_nxt == ST_HALT);
      busy_o      <= (fsm_nxt inside {ST_READ, ST_FETCH, ST_IOWAIT, ST_MOVE});
      gpio_stb_o  <= 1'b0;
      unique case (fsm)
        ST_IDLE:   if (run_i || step_i) ss_q <= step_i & ~run_i;
        ST_READ:   if (tape_valid_i) sym_q <= tape_sym_i;
        ST_FETCH:  if (tbl_done_i) begin
                     nst_q       <= ent_nst;
                     tape_dir_o  <= ent_dir;
                     tape_data_o <= (tm_state == IO_RD && gpio_valid_i) ? gpio_i : ent_sym;
                     if (tm_state == IO_WR) begin
                       gpio_o     <= ent_sym;
                       gpio_stb_o <= 1'b1;
                     end
                   end
        ST_IOWAIT: if (gpio_valid_i) tape_data_o <= gpio_i;
        ST_MOVE:   if (tape_done_i) tm_state <= nst_q;
        ST_HALT:   if (clear_i) tm_state <= INIT;
        default: ;
      endcase
    end
  end

  tm_step_counter #(.W(STEP_W)) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (step_cnt_o)
  );

endmodule

// File: tb/tb_tm_fsm_core.sv
// Directed bench for tm_fsm_core with table/tape responder models and a
// move scoreboard; STEP_W is 2 so counter saturation is reachable.
module tb_tm_fsm_core;

  localparam int STATE_W = 7, SYM_W = 8, STEP_W = 2;
  localparam int ADDR_W = STATE_W + SYM_W + 1, ENTRY_W = SYM_W + 1 + STATE_W;
  localparam logic [6:0] HALT_S = 7'h7F, IO_WR = 7'h7E, IO_RD = 7'h7D;

  logic clk = 1'b0, rst_n = 1'b1;
  logic run_i, step_i, clear_i, bp_en_i;
  logic [STATE_W-1:0] bp_state_i;
  logic tbl_valid_o, tbl_done_i;
  logic [ADDR_W-1:0]  tbl_addr_o;
  logic [ENTRY_W-1:0] tbl_data_i;
  logic tape_valid_i, tape_move_o, tape_dir_o, tape_done_i;
  logic [SYM_W-1:0] tape_sym_i, tape_data_o, gpio_i, gpio_o;
  logic gpio_valid_i, gpio_stb_o, halted_o, busy_o;
  logic [STATE_W-1:0] tm_state_o;
  logic [STEP_W-1:0]  step_cnt_o;

  tm_fsm_core #(.STATE_W(STATE_W), .SYM_W(SYM_W), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_i(step_i), .clear_i(clear_i),
    .bp_en_i(bp_en_i), .bp_state_i(bp_state_i),
    .tbl_valid_o(tbl_valid_o), .tbl_addr_o(tbl_addr_o), .tbl_done_i(tbl_done_i),
    .tbl_data_i(tbl_data_i), .tape_valid_i(tape_valid_i), .tape_sym_i(tape_sym_i),
    .tape_move_o(tape_move_o), .tape_dir_o(tape_dir_o), .tape_data_o(tape_data_o),
    .tape_done_i(tape_done_i), .gpio_i(gpio_i), .gpio_valid_i(gpio_valid_i),
    .gpio_o(gpio_o), .gpio_stb_o(gpio_stb_o), .tm_state_o(tm_state_o),
    .step_cnt_o(step_cnt_o), .halted_o(halted_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic dir; logic [7:0] data; } mv_t;
  mv_t exp_q[$];
  logic [15:0] tbl [logic [15:0]];
  logic [7:0]  tape [256];
  logic [7:0]  head;
  int tests = 0, fails = 0, moves_seen = 0, stb_cnt = 0;
  int tape_clr_req = 0, spur_tbl_req = 0, spur_tape_req = 0;
  logic move_en = 1'b1;

  assign tape_sym_i = tape[head];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ent(input logic [7:0] s, input logic d, input logic [6:0] n);
    return {s, d, n};
  endfunction

  function automatic logic [15:0] adr(input logic [6:0] st, input logic [7:0] sy);
    return {st, sy, 1'b0};
  endfunction

  task automatic push(input logic d, input logic [7:0] s);
    exp_q.push_back(mv_t'{d, s});
  endtask

  // Table reader model: one-cycle-latency lookup; unknown addresses halt.
  initial begin : tbl_resp
    int spur_seen = 0;
    tbl_done_i = 1'b0;
    tbl_data_i = '0;
    forever begin
      @(negedge clk);
      if (tbl_done_i) tbl_done_i = 1'b0;
      else if (tbl_valid_o) begin
        tbl_data_i = tbl.exists(tbl_addr_o) ? tbl[tbl_addr_o] : {8'h00, 1'b0, HALT_S};
        tbl_done_i = 1'b1;
      end else if (spur_seen != spur_tbl_req) begin
        spur_seen  = spur_tbl_req;
        tbl_done_i = 1'b1;
      end
    end
  end

  // Tape controller model: checks each move against the scoreboard.
  initial begin : tape_resp
    mv_t e;
    int clr_seen = 0, spur_seen = 0;
    tape_done_i = 1'b0;
    head = '0;
    forever begin
      @(negedge clk);
      if (clr_seen != tape_clr_req) begin
        clr_seen = tape_clr_req;
        foreach (tape[i]) tape[i] = '0;
        head = '0;
      end
      if (tape_done_i) tape_done_i = 1'b0;
      else if (tape_move_o && move_en) begin
        moves_seen++;
        chk("move_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("move_dir", tape_dir_o, e.dir);
          chk("move_data", tape_data_o, e.data);
        end
        tape[head] = tape_data_o;
        head = tape_dir_o ? head + 8'd1 : head - 8'd1;
        tape_done_i = 1'b1;
      end else if (spur_seen != spur_tape_req) begin
        spur_seen   = spur_tape_req;
        tape_done_i = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (gpio_stb_o) stb_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset;
    rst_n = 1'b0; run_i = 0; step_i = 0; clear_i = 0; bp_en_i = 0;
    gpio_valid_i = 0; move_en = 1'b1;
    exp_q.delete();
    tbl.delete();
    tape_clr_req++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted_o && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_halted"}, halted_o, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic load_prog3;
    tbl[adr(7'd0, 8'h00)] = ent(8'h11, 1'b1, 7'd1);
    tbl[adr(7'd1, 8'h00)] = ent(8'h22, 1'b1, 7'd2);
    tbl[adr(7'd2, 8'h00)] = ent(8'h33, 1'b0, HALT_S);
  endtask

  initial begin
    int s0, m0, n;
    run_i = 0; step_i = 0; clear_i = 0; bp_en_i = 0; bp_state_i = '0;
    tape_valid_i = 1'b1; gpio_i = '0; gpio_valid_i = 0;
    tape_clr_req = 1;
    #3 rst_n = 1'b0;
    #2;
    chk("rst_tbl_valid", tbl_valid_o, 0);
    chk("rst_tape_move", tape_move_o, 0);
    chk("rst_gpio_stb", gpio_stb_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_state", tm_state_o, 0);
    chk("rst_cnt", step_cnt_o, 0);
    chk("rst_gpio_o", gpio_o, 0);

    // Three-entry program run to HALT, then HALT holds and clear_i leaves it.
    do_reset();
    load_prog3();
    push(1, 8'h11); push(1, 8'h22); push(0, 8'h33);
    run_i = 1;
    wait_halted("prog3");
    chk("prog3_state", tm_state_o, HALT_S);
    chk("prog3_cnt", step_cnt_o, 3);
    chk("prog3_busy", busy_o, 0);
    chk("prog3_q_empty", exp_q.size(), 0);
    step_i = 1;
    repeat (5) @(negedge clk);
    step_i = 0;
    chk("halt_hold", halted_o, 1);
    chk("halt_hold_state", tm_state_o, HALT_S);
    run_i = 0;
    clear_i = 1; @(negedge clk); clear_i = 0;
    chk("clear_halted", halted_o, 0);
    chk("clear_state", tm_state_o, 0);
    chk("clear_cnt", step_cnt_o, 0);

    // Single step, clear outside HALT, spurious dones, run dropped mid-step.
    tape_clr_req++;
    repeat (2) @(negedge clk);
    push(1, 8'h11);
    step_i = 1; @(negedge clk); step_i = 0;
    wait_idle("step1");
    chk("step1_state", tm_state_o, 1);
    chk("step1_cnt", step_cnt_o, 1);
    repeat (5) @(negedge clk);
    chk("step1_no_more", step_cnt_o, 1);
    clear_i = 1; @(negedge clk); clear_i = 0;
    spur_tbl_req++; spur_tape_req++;
    repeat (4) @(negedge clk);
    chk("noeff_state", tm_state_o, 1);
    chk("noeff_cnt", step_cnt_o, 1);
    chk("noeff_busy", busy_o, 0);
    push(1, 8'h22);
    run_i = 1; @(negedge clk); run_i = 0;
    wait_idle("rundrop");
    chk("rundrop_state", tm_state_o, 2);
    chk("rundrop_cnt", step_cnt_o, 2);
    chk("rundrop_q_empty", exp_q.size(), 0);

    // IO_WR: the entry symbol goes to gpio_o with a single strobe.
    do_reset();
    tbl[adr(7'd0, 8'h00)] = ent(8'h01, 1'b1, IO_WR);
    tbl[adr(IO_WR, 8'h00)] = ent(8'h3C, 1'b1, HALT_S);
    push(1, 8'h01); push(1, 8'h3C);
    s0 = stb_cnt;
    run_i = 1;
    wait_halted("iowr");
    chk("iowr_gpio_o", gpio_o, 8'h3C);
    chk("iowr_stb_pulses", stb_cnt - s0, 1);
    chk("iowr_cnt", step_cnt_o, 2);
    run_i = 0;

    // IO_RD: waits for gpio_valid_i without requesting a move.
    do_reset();
    tbl[adr(7'd0, 8'h00)] = ent(8'h00, 1'b1, IO_RD);
    tbl[adr(IO_RD, 8'h00)] = ent(8'h77, 1'b0, HALT_S);
    push(1, 8'h00); push(0, 8'hA5);
    run_i = 1;
    n = 0;
    while (tm_state_o != IO_RD && n < 200) begin @(negedge clk); n++; end
    chk("iord_reach", tm_state_o, IO_RD);
    m0 = moves_seen;
    repeat (10) @(negedge clk);
    chk("iord_no_move", moves_seen - m0, 0);
    chk("iord_tape_move", tape_move_o, 0);
    chk("iord_busy", busy_o, 1);
    chk("iord_tbl_valid", tbl_valid_o, 0);
    gpio_i = 8'hA5; gpio_valid_i = 1;
    wait_halted("iord");
    chk("iord_tape_data", tape_data_o, 8'hA5);
    chk("iord_cnt", step_cnt_o, 2);
    run_i = 0; gpio_valid_i = 0;

    // Breakpoint on state 5 while free-running; counter saturates at 3.
    do_reset();
    for (int s = 0; s < 6; s++) tbl[adr(7'(s), 8'h00)] = ent(8'h00, 1'b1, 7'(s + 1));
    tbl[adr(7'd6, 8'h00)] = ent(8'h00, 1'b1, 7'd0);
    for (int i = 0; i < 5; i++) push(1, 8'h00);
    bp_en_i = 1; bp_state_i = 7'd5;
    run_i = 1;
    n = 0;
    while (tm_state_o != 7'd5 && n < 300) begin @(negedge clk); n++; end
    run_i = 0;
    chk("bp_reach", tm_state_o, 5);
    chk("bp_stop_busy", busy_o, 0);
    chk("bp_cnt_sat", step_cnt_o, 3);
    chk("bp_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("bp_hold_state", tm_state_o, 5);
    chk("bp_hold_busy", busy_o, 0);
    bp_en_i = 0;
    for (int i = 0; i < 3; i++) begin
      push(1, 8'h00);
      step_i = 1; @(negedge clk); step_i = 0;
      wait_idle("sat_step");
    end
    chk("sat_state", tm_state_o, 1);
    chk("sat_cnt", step_cnt_o, 3);

    // Reset asserted while a move is outstanding, then a clean rerun.
    do_reset();
    load_prog3();
    push(1, 8'h11);
    move_en = 1'b0;
    run_i = 1;
    n = 0;
    while (!tape_move_o && n < 100) begin @(negedge clk); n++; end
    chk("mr_move_seen", tape_move_o, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_tape_move", tape_move_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_tbl_valid", tbl_valid_o, 0);
    chk("mr_state", tm_state_o, 0);
    run_i = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    move_en = 1'b1;
    tape_clr_req++;
    repeat (2) @(negedge clk);
    push(1, 8'h11); push(1, 8'h22); push(0, 8'h33);
    run_i = 1;
    wait_halted("rerun");
    chk("rerun_state", tm_state_o, HALT_S);
    chk("rerun_cnt", step_cnt_o, 3);
    chk("rerun_q_empty", exp_q.size(), 0);
    run_i = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tm_fsm_core.md
TM_FSM_CORE -- requirements
Module: tm_fsm_core

Interface
REQ-001 Parameter STATE_W, default 7, width of the Turing-machine state register.
REQ-002 Parameter SYM_W, default 8, width of one tape symbol.
REQ-003 Parameter STEP_W, default 16, width of the step counter.
REQ-004 Derived widths SHALL be ADDR_W = STATE_W+SYM_W+1 and ENTRY_W = SYM_W+1+STATE_W.
REQ-005 Port list:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  run_i  in  1  level; free-run enable.
  step_i  in  1  one-cycle pulse; execute exactly one step.
  clear_i  in  1  pulse; return from HALT to INIT.
  bp_en_i  in  1  breakpoint enable.
  bp_state_i  in  STATE_W  breakpoint state.
  tbl_valid_o  out  1  table-fetch request.
  tbl_addr_o  out  ADDR_W  {tm_state, symbol, 1'b0}.
  tbl_done_i  in  1  fetch complete, one-cycle pulse.
  tbl_data_i  in  ENTRY_W  entry: [STATE_W-1:0] next state, [STATE_W] dir (1 = right), [ENTRY_W-1:STATE_W+1] new symbol.
  tape_valid_i  in  1  symbol under head valid.
  tape_sym_i  in  SYM_W  symbol under head.
  tape_move_o  out  1  write-and-move request.
  tape_dir_o  out  1  move direction.
  tape_data_o  out  SYM_W  symbol to write.
  tape_done_i  in  1  move complete, one-cycle pulse.
  gpio_i  in  SYM_W  input data.
  gpio_valid_i  in  1  gpio_i holds valid data.
  gpio_o  out  SYM_W  output register.
  gpio_stb_o  out  1  one-cycle pulse when gpio_o is updated.
  tm_state_o  out  STATE_W  current machine state.
  step_cnt_o  out  STEP_W  completed steps, saturating.
  halted_o  out  1  high in HALT.
  busy_o  out  1  high in READ, FETCH, IOWAIT, MOVE.

Function
REQ-006 Machine state constants: INIT = 0, HALT_ST = all ones, IO_WR = all ones - 1, IO_RD = all ones - 2.
REQ-007 Control FSM states: IDLE, READ, FETCH, IOWAIT, MOVE, HALT.
REQ-008 IDLE: run_i or step_i -> READ; the single-step flag is latched as step_i & ~run_i (run_i wins when both are high).
REQ-009 READ: tape_valid_i -> FETCH; tape_sym_i is latched into the symbol register in the same cycle.
REQ-010 FETCH: tbl_valid_o is high and tbl_addr_o is stable until tbl_done_i; on tbl_done_i, next state, dir and symbol are latched.
REQ-011 On tbl_done_i with tm_state == IO_RD: if gpio_valid_i is high, tape_data_o <= gpio_i and go to MOVE; otherwise go to IOWAIT.
REQ-012 IOWAIT: on gpio_valid_i, tape_data_o <= gpio_i and go to MOVE.
REQ-013 On tbl_done_i with tm_state == IO_WR: gpio_o <= entry symbol and gpio_stb_o is high for the next cycle only.
REQ-014 MOVE: tape_move_o is high and tape_dir_o/tape_data_o are stable until tape_done_i.
REQ-015 On tape_done_i, in priority order:
  - commit tm_state and increment step_cnt, saturating at all ones;
  - if the new state == HALT_ST -> HALT;
  - else if (bp_en_i & new state == bp_state_i), the single-step flag, or ~run_i -> IDLE;
  - else -> READ.
REQ-016 HALT: ignores run_i and step_i; clear_i -> IDLE with tm_state = INIT and step_cnt = 0.
REQ-017 clear_i outside HALT SHALL have no effect.
REQ-018 run_i deasserting mid-step SHALL NOT abort the step; the step completes, then the FSM goes to IDLE.
REQ-019 tbl_done_i or tape_done_i arriving outside the matching FSM state SHALL be ignored.

Reset
REQ-020 While rst_n is low, the FSM is in IDLE and tm_state, step_cnt, gpio_o and the latched registers are 0.
REQ-021 While rst_n is low, tbl_valid_o, tape_move_o, gpio_stb_o, halted_o and busy_o are 0.
REQ-022 Reset asserted mid-step SHALL drop requests immediately, with no handshake completion.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding, the INIT/HALT_ST/IO_RD/IO_WR functions of STATE_W, and the entry field offsets.
REQ-024 The saturating step counter SHALL be one sub-module, tm_step_counter.
REQ-025 The SPI table reader and the tape controller remain external and connect through the handshakes above.

Verification
REQ-026 Three-entry program, run_i=1 -> three MOVE handshakes in table order, state HALT_ST, halted_o=1, step_cnt_o=3.
REQ-027 IO_RD with gpio_valid_i=0 -> FSM holds in IOWAIT, no tape_move_o; after gpio_valid_i=1, gpio_i=0xA5 -> tape_data_o=0xA5.
REQ-028 IO_WR entry with symbol 0x3C -> gpio_o=0x3C and exactly one gpio_stb_o pulse.
REQ-029 run_i=0 and a single step_i pulse -> exactly one step, back to IDLE, step_cnt_o incremented by 1.
REQ-030 bp_en_i=1, bp_state_i=5 -> FSM stops in IDLE after the step entering state 5; STEP_W=2 loop -> step_cnt_o saturates at 3.
REQ-031 rst_n pulsed low during MOVE -> outputs reach reset values asynchronously; subsequent run restarts from INIT.
